// File: rtl/conv_acc_pkg.sv
// Shared definitions for the convolution accelerator output stage: state
// encoding, int8 limits and the per-lane quantizer.
package conv_acc_pkg;

  typedef enum logic [2:0] {
    OFM_IDLE,
    OFM_RUN,
    OFM_TAIL,
    OFM_FLUSH,
    OFM_DRAIN
  } ofm_state_t;

  localparam int OFM_BYTE_W     = 8;
  localparam int OFM_WORD_BYTES = 8;
  localparam int OFM_WORD_W     = OFM_BYTE_W * OFM_WORD_BYTES;
  localparam int INT8_MAX       = 127;
  localparam int INT8_MIN       = -128;
  localparam int QUANT_W        = 26;

  localparam logic signed [QUANT_W-1:0] Q_MAX = QUANT_W'(INT8_MAX);
  localparam logic signed [QUANT_W-1:0] Q_MIN = QUANT_W'(INT8_MIN);

  // ReLU, round-half-up right shift, then saturate to int8.
  function automatic logic [OFM_BYTE_W-1:0] ofm_quantize(
    input logic signed [QUANT_W-1:0] sample,
    input logic        [4:0]         shift,
    input logic                      relu
  );
    logic signed [QUANT_W-1:0] acc;
    acc = (relu && sample < 0) ? '0 : sample;
    if (shift != 5'd0) begin
      acc = acc + (QUANT_W'(1) <<< (shift - 5'd1));
    end
    acc = acc >>> shift;
    if (acc > Q_MAX) begin
      return 8'h7f;
    end else if (acc < Q_MIN) begin
      return 8'h80;
    end
    return acc[OFM_BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/ofm_sync_fifo.sv
// Synchronous FIFO for packed output words; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ofm_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ofm_packer.sv
// Output-feature-map packer: quantizes two partial-sum lanes to int8, packs
// bytes into 64-bit words and streams them to the output SRAM via a FIFO.
module ofm_packer
  import conv_acc_pkg::*;
#(
  parameter int DATA_W     = 25,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_conv,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [DATA_W-1:0] ofm_port0,
  input  logic              ofm_port0_v,
  input  logic [DATA_W-1:0] ofm_port1,
  input  logic              ofm_port1_v,
  input  logic              end_conv,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  input  logic              wr_ready,
  output logic              overflow,
  output logic              done
);

  ofm_state_t state, state_next;
  logic       tail_last;
  logic       drain_done;

  logic [4:0] shift_q;
  logic       relu_q;
  logic       accept;

  logic [7:0] qn0, qn1;
  logic [7:0] q0, q1;
  logic       qv0, qv1;

  logic [2:0]            cnt, cnt_next;
  logic [OFM_WORD_W-1:0] word, word_next;
  logic [3:0]            fill;
  logic                  push_req, push_next;
  logic [OFM_WORD_W-1:0] push_word, push_word_next;

  logic                  fifo_full, fifo_empty, pop;
  logic [OFM_WORD_W-1:0] fifo_dout;
  logic [ADDR_W-1:0]     addr;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= OFM_IDLE;
      tail_last <= 1'b0;
    end else begin
      state     <= state_next;
      tail_last <= (state == OFM_TAIL) && (state_next == OFM_TAIL);
    end
  end

  always_comb begin
    state_next = state;
    drain_done = 1'b0;
    if (start_conv) begin
      state_next = OFM_RUN;
    end else begin
      unique case (state)
        OFM_IDLE:  state_next = OFM_IDLE;
        OFM_RUN:   if (end_conv) state_next = OFM_TAIL;
        OFM_TAIL:  if (tail_last) state_next = OFM_FLUSH;
        OFM_FLUSH: state_next = OFM_DRAIN;
        OFM_DRAIN: begin
          if (fifo_empty && !push_req) begin
            state_next = OFM_IDLE;
            drain_done = 1'b1;
          end
        end
        default:   state_next = OFM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (start_conv) begin
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
    end
  end

  assign accept = (state == OFM_RUN || state == OFM_TAIL) && !start_conv;
  assign qn0 = ofm_quantize(QUANT_W'($signed(ofm_port0)), shift_q, relu_q);
  assign qn1 = ofm_quantize(QUANT_W'($signed(ofm_port1)), shift_q, relu_q);

  always_ff @(posedge clk) begin
    if (rst_n || start_conv) begin
      qv0 <= 1'b0;
      qv1 <= 1'b0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      qv0 <= accept && ofm_port0_v;
      qv1 <= accept && ofm_port1_v;
      q0  <= qn0;
      q1  <= qn1;
    end
  end

  // fill = slots used after this cycle's bytes; 8 or 9 completes a word and
  // fill[2:0] is the carry-over count into the next word.
  always_comb begin
    word_next      = word;
    cnt_next       = cnt;
    push_next      = 1'b0;
    push_word_next = push_word;
    fill           = {1'b0, cnt};
    if (qv0 || qv1) begin
      word_next[{cnt, 3'b000} +: 8] = qv0 ? q0 : q1;
      if (qv0 && qv1) begin
        if (cnt != 3'd7) word_next[{cnt + 3'd1, 3'b000} +: 8] = q1;
        fill = {1'b0, cnt} + 4'd2;
      end else begin
        fill = {1'b0, cnt} + 4'd1;
      end
      if (fill[3]) begin
        push_next      = 1'b1;
        push_word_next = word_next;
        word_next      = '0;
        if (fill[0]) word_next[7:0] = q1;
      end
      cnt_next = fill[2:0];
    end
    if (state == OFM_FLUSH && !push_next && cnt_next != 3'd0) begin
      push_next      = 1'b1;
      push_word_next = word_next;
      word_next      = '0;
      cnt_next       = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n || start_conv) begin
      cnt       <= '0;
      word      <= '0;
      push_req  <= 1'b0;
      push_word <= '0;
    end else begin
      cnt       <= cnt_next;
      word      <= word_next;
      push_req  <= push_next;
      push_word <= push_word_next;
    end
  end

  ofm_sync_fifo #(
    .WIDTH (OFM_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .clr   (start_conv),
    .push  (push_req),
    .pop   (pop),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = !fifo_empty && wr_ready;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      addr     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= drain_done;
      if (start_conv) begin
        addr     <= cfg_base_addr;
        overflow <= 1'b0;
      end else begin
        if (pop) addr <= addr + 1'b1;
        if (push_req && fifo_full && !pop) overflow <= 1'b1;
      end
    end
  end

  assign wr_en   = !fifo_empty;
  assign wr_addr = addr;
  assign wr_data = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_ofm_packer.sv
// Directed and randomized checks of ofm_packer against a byte-stream model.
module tb_ofm_packer;

  localparam int DATA_W = 25;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start_conv = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [4:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic [DATA_W-1:0] ofm_port0 = '0;
  logic              ofm_port0_v = 1'b0;
  logic [DATA_W-1:0] ofm_port1 = '0;
  logic              ofm_port1_v = 1'b0;
  logic              end_conv = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              wr_ready = 1'b1;
  logic              overflow;
  logic              done;

  ofm_packer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_conv    (start_conv),
    .cfg_base_addr (cfg_base_addr),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .ofm_port0     (ofm_port0),
    .ofm_port0_v   (ofm_port0_v),
    .ofm_port1     (ofm_port1),
    .ofm_port1_v   (ofm_port1_v),
    .end_conv      (end_conv),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_cnt = 0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic [63:0]       obs_data[$];
  logic [7:0]        exp_bytes[$];
  int                m_shift;
  bit                m_relu;
  int                m_base;

  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] q_ref(input int x);
    int v;
    v = x;
    if (m_relu && v < 0) v = 0;
    if (m_shift > 0) v = (v + (1 << (m_shift - 1))) >>> m_shift;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic start(input int base, input int shift, input bit relu);
    cfg_base_addr = ADDR_W'(base);
    cfg_shift     = 5'(shift);
    cfg_relu      = relu;
    start_conv    = 1'b1;
    tick();
    start_conv = 1'b0;
    m_base  = base;
    m_shift = shift;
    m_relu  = relu;
    exp_bytes.delete();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic drive(input bit v0, input int d0, input bit v1, input int d1);
    ofm_port0_v = v0;
    ofm_port0   = d0[DATA_W-1:0];
    ofm_port1_v = v1;
    ofm_port1   = d1[DATA_W-1:0];
    tick();
    ofm_port0_v = 1'b0;
    ofm_port1_v = 1'b0;
    if (v0) exp_bytes.push_back(q_ref(d0));
    if (v1) exp_bytes.push_back(q_ref(d1));
  endtask

  task automatic finish(input string tag);
    int unsigned d0;
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    chk({tag, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
    while (exp_bytes.size() % 8 != 0) exp_bytes.push_back(8'h00);
  endtask

  task automatic check_writes(input string tag, input int limit);
    int n;
    logic [63:0] w;
    n = exp_bytes.size() / 8;
    if (limit < n) n = limit;
    chk({tag, ".nwrites"}, 64'(obs_data.size()), 64'(n));
    for (int k = 0; k < n && k < obs_data.size(); k++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = exp_bytes[8*k + b];
      chk($sformatf("%s.addr%0d", tag, k), 64'(obs_addr[k]), 64'((m_base + k) % (1 << ADDR_W)));
      chk($sformatf("%s.data%0d", tag, k), obs_data[k], w);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("reset.wr_en", 64'(wr_en), 64'd0);
    chk("reset.wr_addr", 64'(wr_addr), 64'd0);
    chk("reset.wr_data", wr_data, 64'd0);
    chk("reset.overflow", 64'(overflow), 64'd0);
    chk("reset.done", 64'(done), 64'd0);

    // Basic packing with exact write latency
    start('h010, 0, 1'b0);
    drive(1, 1, 1, 2);
    drive(1, 3, 1, 4);
    drive(1, 5, 1, 6);
    drive(1, 7, 1, 8);
    chk("basic.lat0", 64'(wr_en), 64'd0);
    tick();
    chk("basic.lat1", 64'(wr_en), 64'd0);
    tick();
    chk("basic.lat2", 64'(wr_en), 64'd1);
    chk("basic.addr", 64'(wr_addr), 64'h010);
    chk("basic.data", wr_data, 64'h0807060504030201);
    finish("basic");
    check_writes("basic", 99);

    // Quantize, ReLU and saturation with a partial-word flush
    start('h080, 4, 1'b1);
    drive(1, -500, 0, 0);
    drive(1, 23, 0, 0);
    drive(1, 24, 0, 0);
    drive(1, 40000, 0, 0);
    finish("quant");
    check_writes("quant", 99);
    if (obs_data.size() > 0) chk("quant.const", obs_data[0], 64'h000000007F020100);

    // Odd alignment: two bytes straddle a word boundary
    start('h100, 0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1, i + 1, 0, 0);
    drive(1, 'h11, 1, 'h22);
    finish("odd");
    check_writes("odd", 99);
    if (obs_data.size() > 1) begin
      chk("odd.byte7", 64'(obs_data[0][63:56]), 64'h11);
      chk("odd.word1", obs_data[1], 64'h22);
      chk("odd.addr1", 64'(obs_addr[1]), 64'h101);
    end

    // Backpressure: six words into a four-deep FIFO
    start('h200, 2, 1'b0);
    wr_ready = 1'b0;
    for (int i = 0; i < 24; i++) drive(1, int'($urandom) >>> 7, 1, int'($urandom) >>> 7);
    repeat (4) tick();
    chk("bp.overflow", 64'(overflow), 64'd1);
    chk("bp.wr_en_held", 64'(wr_en), 64'd1);
    chk("bp.no_writes", 64'(obs_data.size()), 64'd0);
    wr_ready = 1'b1;
    finish("bp");
    check_writes("bp", 4);
    chk("bp.overflow_sticky", 64'(overflow), 64'd1);

    // Randomized run with extremes, random lanes and random wr_ready
    start('h2F0, int'($urandom_range(0, 24)), 1'($urandom));
    chk("rand.overflow_cleared", 64'(overflow), 64'd0);
    drive(1, -(1 << 24), 1, (1 << 24) - 1);
    for (int i = 0; i < 60; i++) begin
      wr_ready = ($urandom_range(0, 7) != 0);
      drive(1'($urandom), int'($urandom) >>> 7, 1'($urandom), int'($urandom) >>> 7);
    end
    wr_ready = 1'b1;
    finish("rand");
    check_writes("rand", 999);
    chk("rand.overflow", 64'(overflow), 64'd0);

    // Address wrap
    start('h3FF, 0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1, 2 * i, 1, 2 * i + 1);
    finish("wrap");
    check_writes("wrap", 99);
    if (obs_addr.size() > 1) begin
      chk("wrap.addr0", 64'(obs_addr[0]), 64'h3FF);
      chk("wrap.addr1", 64'(obs_addr[1]), 64'h000);
    end

    // Mid-operation reset with one queued word and three pending bytes
    start('h020, 0, 1'b0);
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 10 + i, 1, 20 + i);
    drive(1, 30, 1, 31);
    drive(1, 32, 0, 0);
    repeat (4) tick();
    chk("mrst.queued", 64'(wr_en), 64'd1);
    rst_n = 1'b1;
    tick();
    chk("mrst.wr_en", 64'(wr_en), 64'd0);
    chk("mrst.wr_addr", 64'(wr_addr), 64'd0);
    chk("mrst.wr_data", wr_data, 64'd0);
    chk("mrst.overflow", 64'(overflow), 64'd0);
    chk("mrst.done", 64'(done), 64'd0);
    rst_n = 1'b0;
    wr_ready = 1'b1;
    repeat (5) tick();
    chk("mrst.no_writes", 64'(obs_data.size()), 64'd0);
    start('h040, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1, 40 + i, 1, 50 + i);
    finish("after_rst");
    check_writes("after_rst", 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
